// File: rtl/ca90_item_gen.sv
// Sequential CA90 item-memory generator: walks seed -> item[idx] one step per clock,
// caching the last vector so ascending requests resume instead of restarting.

module fixed_ca90_unit #(
    parameter int Dimension = 512,
    parameter int ShiftAmt  = 1
) (
    input  logic [Dimension-1:0] i_data,
    output logic [Dimension-1:0] o_data
);
    logic [Dimension-1:0] w_rotl;
    logic [Dimension-1:0] w_rotr;

    assign w_rotl = {i_data[Dimension-1-ShiftAmt:0], i_data[Dimension-1 -: ShiftAmt]};
    assign w_rotr = {i_data[ShiftAmt-1:0], i_data[Dimension-1:ShiftAmt]};
    assign o_data = w_rotl ^ w_rotr;
endmodule

module ca90_item_gen #(
    parameter int Dimension = 512,
    parameter int ShiftAmt  = 1,
    parameter int NumItems  = 1024,
    parameter int IdxWidth  = $clog2(NumItems)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [Dimension-1:0] seed_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IdxWidth-1:0]  req_idx_i,
    output logic                 item_valid_o,
    input  logic                 item_ready_i,
    output logic [Dimension-1:0] item_o
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

    state_e               r_fsm;
    state_e               w_fsm_nxt;
    logic [Dimension-1:0] state_q;
    logic [IdxWidth-1:0]  cur_idx_q;
    logic [IdxWidth-1:0]  target_q;
    logic                 cache_valid_q;
    logic [Dimension-1:0] w_step;
    logic                 w_accept;
    logic                 w_continue;
    logic                 w_at_target;

    fixed_ca90_unit #(
        .Dimension(Dimension),
        .ShiftAmt (ShiftAmt)
    ) u_step (
        .i_data(state_q),
        .o_data(w_step)
    );

    assign w_accept    = req_valid_i && (r_fsm == S_IDLE);
    assign w_continue  = cache_valid_q && !flush_i && (req_idx_i >= cur_idx_q);
    assign w_at_target = (cur_idx_q == target_q);
    assign item_o      = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_fsm <= S_IDLE;
        else       r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt    = r_fsm;
        req_ready_o  = 1'b0;
        item_valid_o = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) w_fsm_nxt = S_ITER;
            end
            S_ITER: begin
                if (w_at_target) w_fsm_nxt = S_DONE;
            end
            S_DONE: begin
                item_valid_o = 1'b1;
                if (item_ready_i) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // A restart's cache set is written after the flush clear so it wins on coincidence.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= '0;
            cur_idx_q     <= '0;
            target_q      <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            if (flush_i) cache_valid_q <= 1'b0;
            if (w_accept) begin
                target_q <= req_idx_i;
                if (!w_continue) begin
                    state_q       <= seed_i;
                    cur_idx_q     <= '0;
                    cache_valid_q <= 1'b1;
                end
            end else if (r_fsm == S_ITER && !w_at_target) begin
                state_q   <= w_step;
                cur_idx_q <= cur_idx_q + IdxWidth'(1);
            end
        end
    end
endmodule

// File: tb/tb_ca90_item_gen.sv
// Directed bench for ca90_item_gen (D=8, shift 1, 16 items, seed 0x01) with a
// per-cycle comparison against a request-level model.

module tb_ca90_item_gen;
    localparam int D = 8;
    localparam int N = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [D-1:0]  seed;
    logic          flush;
    logic          req_valid;
    logic          req_ready_o;
    logic [IW-1:0] req_idx;
    logic          item_valid_o;
    logic          item_ready;
    logic [D-1:0]  item_o;

    int errors = 0;
    int checks = 0;
    bit go = 0;

    always #5 clk = ~clk;

    ca90_item_gen #(.Dimension(D), .ShiftAmt(1), .NumItems(N)) dut (
        .clk_i(clk), .rst_i(rst), .seed_i(seed), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_idx_i(req_idx),
        .item_valid_o(item_valid_o), .item_ready_i(item_ready), .item_o(item_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] ca90n(input logic [D-1:0] v0, input int n);
        logic [D-1:0] v;
        v = v0;
        for (int k = 0; k < n; k++)
            v = ((v << 1) | (v >> (D - 1))) ^ ((v >> 1) | (v << (D - 1)));
        return v;
    endfunction

    // Request-level model: a busy countdown of s+1 edges, then the cached result.
    logic         m_ready, m_valid, m_cache_valid;
    logic [D-1:0] m_item, m_cache_vec;
    int           m_cache_idx, m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1; m_valid = 0; m_item = '0; m_cnt = 0;
            m_cache_valid = 0; m_cache_idx = 0; m_cache_vec = '0;
        end else if (m_ready && req_valid) begin
            int s;
            bit cont;
            cont = m_cache_valid && !flush && (int'(req_idx) >= m_cache_idx);
            s = cont ? int'(req_idx) - m_cache_idx : int'(req_idx);
            m_item = ca90n(cont ? m_cache_vec : seed, s);
            m_cache_vec = m_item;
            m_cache_idx = int'(req_idx);
            m_cache_valid = 1;
            m_cnt = s + 1;
            m_ready = 0;
        end else begin
            if (flush) m_cache_valid = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_valid = 1;
            end else if (m_valid && item_ready) begin
                m_valid = 0;
                m_ready = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("model item_valid", int'(item_valid_o), int'(m_valid));
            chk("model req_ready", int'(req_ready_o), int'(m_ready));
            if (m_valid) chk("model item", int'(item_o), int'(m_item));
        end
    end

    task automatic do_req(input int idx, input int exp_item, input int exp_lat,
                          input int bp, input int flush_at);
        int n;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready before request", int'(req_ready_o), 1);
        req_valid = 1;
        req_idx = IW'(idx);
        if (bp > 0) item_ready = 0;
        @(posedge clk);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (n == 0) req_valid = 0;
            flush = (n == flush_at);
            if (item_valid_o || n > 40) break;
            @(posedge clk);
            n++;
        end
        flush = 0;
        chk($sformatf("latency idx%0d", idx), n, exp_lat);
        chk($sformatf("item idx%0d", idx), int'(item_o), exp_item);
        for (int k = 0; k < bp; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp valid held", int'(item_valid_o), 1);
            chk("bp ready low", int'(req_ready_o), 0);
            chk("bp item stable", int'(item_o), exp_item);
        end
        item_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("idle after handshake", int'(req_ready_o), 1);
    endtask

    initial begin
        rst = 1; seed = 8'h01; flush = 0; req_valid = 0; req_idx = '0; item_ready = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        go = 1;

        // 1: mid-cycle reset, then idx 0
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("rst item_valid", int'(item_valid_o), 0);
        chk("rst req_ready", int'(req_ready_o), 1);
        chk("rst item", int'(item_o), 0);
        @(negedge clk);
        rst = 0;
        do_req(0, 8'h01, 1, 0, -1);

        // 2: continue from cache
        do_req(3, 8'hAA, 4, 0, -1);

        // 3: restart on lower index, then continue
        do_req(2, 8'h44, 3, 0, -1);
        do_req(4, 8'h00, 3, 0, -1);

        // 4: backpressure (restart, 1 step)
        do_req(1, 8'h82, 2, 5, -1);

        // 5: flush during ITER of idx 3 (continue from 1), then idx 4 restarts
        do_req(3, 8'hAA, 3, 0, 0);
        do_req(4, 8'h00, 5, 0, -1);

        // 6: reset during ITER of idx 15
        req_valid = 1;
        req_idx = 4'd15;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("rst2 item_valid", int'(item_valid_o), 0);
        chk("rst2 req_ready", int'(req_ready_o), 1);
        chk("rst2 item", int'(item_o), 0);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("no result after reset", int'(item_valid_o), 0);
        end
        do_req(1, 8'h82, 2, 0, -1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
